// File: rtl/act_skew_feeder_pkg.sv
// Shared configuration for the activation skew feeder: array geometry, feeder states
// and the activation vector type.
package act_skew_feeder_pkg;

    localparam int sys_rows           = 4;
    localparam int A_BITWIDTH         = 8;
    localparam int input_buffer_depth = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    typedef logic [sys_rows-1:0][A_BITWIDTH-1:0] a_vec_t;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int counter_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/act_skew_feeder_if.sv
// Vector write channel into the feeder and the skewed activation bus out to the PE grid.
interface act_skew_feeder_if
    import act_skew_feeder_pkg::*;
#(
    parameter int ROWS = sys_rows,
    parameter int DW   = A_BITWIDTH
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic [ROWS*DW-1:0]   sa_data;
    logic [ROWS-1:0]      sa_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sa_data,
        input  sa_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sa_data,
        output sa_valid
    );

endinterface

// File: rtl/act_skew_feeder_skew_delay_line.sv
// Per-row skew stage: a DELAY-deep register chain carrying one element and its valid.
// DELAY=0 degenerates to a plain wire.
module skew_delay_line
    import act_skew_feeder_pkg::*;
#(
    parameter int DW    = A_BITWIDTH,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o
);

    generate
        if (DELAY == 0) begin : g_wire
            logic unusedClkRst;
            assign unusedClkRst = clk ^ rst;
            assign data_o       = data_i;
            assign valid_o      = valid_i;
        end else begin : g_chain
            logic [DELAY-1:0][DW-1:0] data_q;
            logic [DELAY-1:0]         valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= data_i;
                    valid_q[0] <= valid_i;
                    for (int i = 1; i < DELAY; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign data_o  = data_q[DELAY-1];
            assign valid_o = valid_q[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/act_skew_feeder.sv
// Activation buffer plus diagonal skew into the systolic array (row r lags row 0 by r cycles).
// Define ACT_REPLAY_EN to keep streamed vectors and rewind the read pointer for re-streaming.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int ROWS  = sys_rows,
    parameter int DW    = A_BITWIDTH,
    parameter int DEPTH = input_buffer_depth,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    act_skew_feeder_if.slave     bus,
    input  logic                 start_i,
    input  logic [CW-1:0]        num_vecs_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cmd_err_o,
    output logic [CW-1:0]        count_o
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DCW = counter_width(ROWS);
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'((ROWS > 1) ? ROWS - 2 : 0);

    typedef logic [ROWS-1:0][DW-1:0] vec_t;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    vec_t              mem [DEPTH];
    feeder_state_t     state_q;
    logic [PW-1:0]     wrPtr_q;
    logic [PW-1:0]     rdPtr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     remain_q;
    logic [DCW-1:0]    drain_q;
    logic              busy_q;
    logic              done_q;
    logic              cmdErr_q;
    vec_t              outData_q;
    logic              outValid_q;
`ifdef ACT_REPLAY_EN
    logic [PW-1:0]     startPtr_q;
`else
    logic [CW-1:0]     numVecs_q;
`endif

    logic wrEn;
    logic legalStart;
    logic doRead;

    // The legality check deliberately uses count_q, i.e. the count before any same-cycle write.
    assign wrEn       = bus.in_valid && bus.in_ready;
    assign legalStart = (num_vecs_i >= CW'(1)) && (num_vecs_i <= count_q);
    assign doRead     = ((state_q == IDLE) && start_i && legalStart) ||
                        ((state_q == STREAM) && (remain_q != '0));

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr_q] <= vec_t'(bus.in_data);
        end
    end

    always_comb begin
        count_d = count_q;
        if (wrEn) begin
            count_d = count_q + CW'(1);
        end
`ifndef ACT_REPLAY_EN
        if (state_q == DONE) begin
            count_d = count_q - numVecs_q;
        end
`endif
    end

    // The first vector is fetched on the start edge itself so row 0 is valid the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmdErr_q   <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
`ifdef ACT_REPLAY_EN
            startPtr_q <= '0;
`else
            numVecs_q  <= '0;
`endif
        end else begin
            cmdErr_q   <= 1'b0;
            done_q     <= 1'b0;
            outValid_q <= doRead;
            outData_q  <= doRead ? mem[rdPtr_q] : '0;
            count_q    <= count_d;
            if (doRead) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            if (wrEn) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (legalStart) begin
                            state_q  <= STREAM;
                            busy_q   <= 1'b1;
                            remain_q <= num_vecs_i - CW'(1);
`ifdef ACT_REPLAY_EN
                            startPtr_q <= rdPtr_q;
`else
                            numVecs_q  <= num_vecs_i;
`endif
                        end else begin
                            cmdErr_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (remain_q != '0) begin
                        remain_q <= remain_q - CW'(1);
                    end else if (ROWS > 1) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_INIT;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q != '0) begin
                        drain_q <= drain_q - DCW'(1);
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef ACT_REPLAY_EN
                    rdPtr_q <= startPtr_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));

    vec_t            rowData;
    logic [ROWS-1:0] rowValid;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            skew_delay_line #(
                .DW    (DW),
                .DELAY (r)
            ) u_skew (
                .clk     (clk),
                .rst     (rst),
                .data_i  (outData_q[r]),
                .valid_i (outValid_q),
                .data_o  (rowData[r]),
                .valid_o (rowValid[r])
            );
        end
    endgenerate

    assign bus.sa_data  = rowData;
    assign bus.sa_valid = rowValid;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cmd_err_o    = cmdErr_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: directed scenarios plus randomized load/stream rounds.
// Build with ACT_REPLAY_EN defined to exercise the replay variant.
module tb_act_skew_feeder;
    import act_skew_feeder_pkg::*;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        int             cyc;
        logic [DW-1:0]  val;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [CW-1:0]  numVecs = '0;
    logic           busy;
    logic           done;
    logic           cmdErr;
    logic [CW-1:0]  count;

    act_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) bus ();

    act_skew_feeder #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .start_i    (start),
        .num_vecs_i (numVecs),
        .busy_o     (busy),
        .done_o     (done),
        .cmd_err_o  (cmdErr),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a plain FIFO of buffered vectors plus expected-event queues.
    a_vec_t modelBuf[$];
    beat_t  rowQ[ROWS][$];
    int     doneQ[$];
    int     errQ[$];
    int     busyLo = -1;
    int     busyHi = -1;
    int     total = 0;
    int     bad = 0;

    function automatic void checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void failNote(input string name, input int act, input int exp);
        total++;
        bad++;
        $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic bit rowsPending();
        for (int r = 0; r < ROWS; r++) if (rowQ[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void clearModel();
        modelBuf.delete();
        for (int r = 0; r < ROWS; r++) rowQ[r].delete();
        doneQ.delete();
        errQ.delete();
        busyLo = -1;
        busyHi = -1;
    endfunction

    // Monitor: every beat, pulse and busy level is matched against what the model queued.
    always @(negedge clk) begin
        beat_t         e;
        logic [DW-1:0] got;
        if (rst === 1'b0) begin
            for (int r = 0; r < ROWS; r++) begin
                got = bus.sa_data[r*DW +: DW];
                if (bus.sa_valid[r]) begin
                    if (rowQ[r].size() == 0) begin
                        failNote($sformatf("row%0d_unexpected_beat", r), int'(got), -1);
                    end else begin
                        e = rowQ[r].pop_front();
                        checkVal($sformatf("row%0d_cycle", r), 64'(cyc), 64'(e.cyc));
                        checkVal($sformatf("row%0d_data", r), 64'(got), 64'(e.val));
                    end
                end else begin
                    if (rowQ[r].size() > 0 && rowQ[r][0].cyc <= cyc) begin
                        e = rowQ[r].pop_front();
                        failNote($sformatf("row%0d_missing_beat", r), 0, int'(e.val));
                    end
                    checkVal($sformatf("row%0d_idle_zero", r), 64'(got), 64'(0));
                end
            end

            if (done) begin
                if (doneQ.size() == 0) failNote("done_unexpected", cyc, -1);
                else checkVal("done_cycle", 64'(cyc), 64'(doneQ.pop_front()));
            end else if (doneQ.size() > 0 && doneQ[0] <= cyc) begin
                failNote("done_missing", -1, doneQ.pop_front());
            end

            if (cmdErr) begin
                if (errQ.size() == 0) failNote("cmd_err_unexpected", cyc, -1);
                else checkVal("cmd_err_cycle", 64'(cyc), 64'(errQ.pop_front()));
            end else if (errQ.size() > 0 && errQ[0] <= cyc) begin
                failNote("cmd_err_missing", -1, errQ.pop_front());
            end

            checkVal("busy", 64'(busy), 64'((cyc >= busyLo) && (cyc <= busyHi)));
        end
    end

    task automatic writeVec(input a_vec_t v);
        bit expReady;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        expReady = modelBuf.size() < DEPTH;
        checkVal("in_ready", 64'(bus.in_ready), 64'(expReady));
        if (expReady) modelBuf.push_back(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Issue a start (optionally with a same-cycle write) and queue the expected skewed stream.
    task automatic applyStimulus(input int n, input bit withWrite, input a_vec_t wv);
        int t;
        bit legal;
        bit expReady;
        @(posedge clk); #1;
        t       = cyc;
        start   = 1'b1;
        numVecs = CW'(n);
        if (withWrite) begin
            bus.in_valid = 1'b1;
            bus.in_data  = wv;
        end
        legal = (n >= 1) && (n <= modelBuf.size());
        if (legal) begin
            for (int k = 0; k < n; k++)
                for (int r = 0; r < ROWS; r++)
                    rowQ[r].push_back('{t + 1 + r + k, modelBuf[k][r]});
            doneQ.push_back(t + n + ROWS);
            busyLo = t + 1;
            busyHi = t + n + ROWS - 1;
        end else begin
            errQ.push_back(t + 1);
        end
        if (withWrite) begin
            expReady = modelBuf.size() < DEPTH;
            checkVal("in_ready_at_start", 64'(bus.in_ready), 64'(expReady));
            if (expReady) modelBuf.push_back(wv);
        end
`ifndef ACT_REPLAY_EN
        if (legal) repeat (n) void'(modelBuf.pop_front());
`endif
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic pokeStart(input int n);
        @(posedge clk); #1;
        start   = 1'b1;
        numVecs = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((doneQ.size() > 0 || errQ.size() > 0 || rowsPending()) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            failNote("wait_idle_timeout", guard, 300);
            clearModel();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        checkVal("count", 64'(count), 64'(modelBuf.size()));
        checkVal("in_ready_idle", 64'(bus.in_ready), 64'(modelBuf.size() < DEPTH));
        checkVal("busy_idle", 64'(busy), 64'(0));
    endtask

    function automatic a_vec_t randVec();
        a_vec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = DW'($urandom);
        return v;
    endfunction

    initial begin
        #2000000;
        failNote("global_timeout", cyc, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        a_vec_t v;
        int     n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_sa_valid", 64'(bus.sa_valid), 64'(0));
        checkVal("reset_done", 64'(done), 64'(0));
        rst = 1'b0;
        checkOutput();

        // Four known vectors: row r of v_k is 16k+r.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) v[r] = DW'(16 * k + r);
            writeVec(v);
        end
        applyStimulus(4, 1'b0, '0);
        waitIdle();
        checkOutput();

        // Fill the buffer, overflow attempt, oversize start, then drain it.
        repeat (DEPTH + 1) writeVec(randVec());
        applyStimulus(DEPTH + 1, 1'b0, '0);
        waitIdle();
        checkOutput();
        applyStimulus(modelBuf.size(), 1'b0, '0);
        waitIdle();
        checkOutput();

        // Zero-length start is illegal; a start while busy is ignored.
        rst = 1'b1; clearModel(); #1; rst = 1'b0;
        repeat (3) writeVec(randVec());
        applyStimulus(0, 1'b0, '0);
        waitIdle();
        checkOutput();
        applyStimulus(2, 1'b0, '0);
        pokeStart(2);
        waitIdle();
        checkOutput();

        // Pointer wrap: 14 in, 14 out, 5 more in, 5 out.
        rst = 1'b1; clearModel(); #1; rst = 1'b0;
        repeat (14) writeVec(randVec());
        applyStimulus(14, 1'b0, '0);
        waitIdle();
        repeat (5) writeVec(randVec());
        applyStimulus(5, 1'b0, '0);
        waitIdle();
        checkOutput();

        // Reset in the middle of an N=6 stream.
        rst = 1'b1; clearModel(); #1; rst = 1'b0;
        repeat (6) writeVec(randVec());
        applyStimulus(6, 1'b0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clearModel();
        #1;
        checkVal("midreset_sa_valid", 64'(bus.sa_valid), 64'(0));
        checkVal("midreset_sa_data", 64'(bus.sa_data), 64'(0));
        checkVal("midreset_count", 64'(count), 64'(0));
        checkVal("midreset_busy", 64'(busy), 64'(0));
        checkVal("midreset_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput();

`ifdef ACT_REPLAY_EN
        // Replay: the same three vectors stream twice and stay buffered.
        repeat (3) writeVec(randVec());
        applyStimulus(3, 1'b0, '0);
        waitIdle();
        applyStimulus(3, 1'b0, '0);
        waitIdle();
        checkOutput();
        rst = 1'b1; clearModel(); #1; rst = 1'b0;
`endif

        // Randomized rounds, including illegal lengths and same-cycle writes.
        for (int round = 0; round < 10; round++) begin
            repeat ($urandom_range(0, 6)) writeVec(randVec());
            n = $urandom_range(0, modelBuf.size() + 1);
            applyStimulus(n, 1'($urandom_range(0, 1)), randVec());
            waitIdle();
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
